lfsr_sbox_table_builder: RTL

//   Table writer for the LFSR-derived S-box. After start, walks the 8-bit LFSR one step per cycle.

---
 rtl/aes_sbox_pkg.sv | 29 ++
 rtl/lfsr8_fib.sv | 18 +
 rtl/lfsr_sbox_table_builder.sv | 119 +++++++++++
 3 files changed

// File: rtl/aes_sbox_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// aes_sbox_pkg: shared constants, state encoding and byte index helpers
// Rev 1.0
// ------------------------------------------------------------------
package aes_sbox_pkg;

  localparam logic [7:0] SBOX_SEED     = 8'h1D;
  // Feedback taps at bits 4,3,2,0 (polynomial x^8+x^4+x^3+x^2+1)
  localparam logic [7:0] SBOX_TAPS     = 8'b0001_1101;
  localparam logic [7:0] SBOX_LAST_VAL = 8'h00;
  localparam logic [7:0] SBOX_LAST_IDX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUILD = 2'd1,
    READY = 2'd2
  } build_state_e;

  function automatic logic [3:0] byte_row(input logic [7:0] b);
    return b[7:4];
  endfunction

  function automatic logic [3:0] byte_col(input logic [7:0] b);
    return b[3:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr8_fib.sv
`default_nettype none
// ------------------------------------------------------------------
// lfsr8_fib: combinational next state of the 8-bit right-shifting Fibonacci LFSR
// Rev 1.0
// ------------------------------------------------------------------
module lfsr8_fib
  import aes_sbox_pkg::*;
#(
  parameter logic [7:0] TAPS = SBOX_TAPS
) (
  input  logic [7:0] cur,
  output logic [7:0] nxt
);

  assign nxt = {^(cur & TAPS), cur[7:1]};

endmodule
`default_nettype wire

// File: rtl/lfsr_sbox_table_builder.sv
`default_nettype none
// ------------------------------------------------------------------
// lfsr_sbox_table_builder: one-shot builder of forward/inverse LFSR S-box
// tables with a registered lookup port.  Rev 1.0
// ------------------------------------------------------------------
module lfsr_sbox_table_builder
  import aes_sbox_pkg::*;
#(
  parameter logic [7:0] SEED     = SBOX_SEED,
  parameter logic [7:0] LAST_VAL = SBOX_LAST_VAL
) (
  input  logic       clk,
  input  logic       rst_an,
  input  logic       start,
  output logic       busy,
  output logic       ready,
  output logic       done,
  input  logic       rd_en,
  input  logic       select,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       rd_valid
);

  build_state_e state_q, state_d;
  logic [7:0]   k_q, k_d;
  logic [7:0]   lfsr_q, lfsr_d;
  logic         done_q, done_d;
  logic         rd_valid_q, rd_valid_d;
  logic [7:0]   rd_data_q, rd_data_d;

  logic [7:0]   lfsr_nxt;
  logic         wr_en;
  logic [7:0]   wr_val;
  logic         rd_hit;

  logic [7:0]   fwd_q [256];
  logic [7:0]   inv_q [256];

  lfsr8_fib #(.TAPS(SBOX_TAPS)) u_lfsr (
    .cur (lfsr_q),
    .nxt (lfsr_nxt)
  );

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      state_q    <= IDLE;
      k_q        <= 8'h00;
      lfsr_q     <= SEED;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      lfsr_q     <= lfsr_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, READY: if (start) state_d = BUILD;
      BUILD:       if (k_q == SBOX_LAST_IDX) state_d = READY;
      default:     state_d = IDLE;
    endcase
  end

  // Build datapath: k stops at 255, so the walk never starts a second pass.
  always_comb begin
    k_d    = k_q;
    lfsr_d = lfsr_q;
    done_d = 1'b0;
    wr_en  = 1'b0;
    wr_val = lfsr_q;
    if (state_q == BUILD) begin
      wr_en = 1'b1;
      if (k_q == SBOX_LAST_IDX) begin
        wr_val = LAST_VAL;
        done_d = 1'b1;
      end else begin
        k_d    = k_q + 8'd1;
        lfsr_d = lfsr_nxt;
      end
    end else if (start) begin
      k_d    = 8'h00;
      lfsr_d = SEED;
    end
  end

  always_comb begin
    busy  = (state_q == BUILD);
    ready = (state_q == READY);
  end

  // Table writes and lookups never collide: writes only happen outside READY.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fwd_q[k_q]    <= wr_val;
      inv_q[wr_val] <= k_q;
    end
  end

  always_comb begin
    rd_hit     = rd_en & ready;
    rd_valid_d = rd_hit;
    rd_data_d  = rd_data_q;
    if (rd_hit) rd_data_d = select ? fwd_q[rd_addr] : inv_q[rd_addr];
  end

  assign done     = done_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule
`default_nettype wire
